// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Moore-style sequencer and instruction decoder for the datapath. It steps
// through fetch (IF1, IF2, UPC), decode, and the per-instruction execute,
// memory and writeback states. It drives every datapath control strobe, the
// memory command, and the PC and address-register loads.
//
// Every output is a registered function of the state being entered. The
// register-number, shift and ALU fields are taken from the instruction
// register, which stays stable from DECODE to the end of the instruction.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   ir         instruction: [15:13] opcode, [12:11] op, [10:8] Rn,
//              [7:5] Rd, [4:3] shift, [2:0] Rm
//   Z_out      datapath status flags {V,N,Z}; observed only
//   readnum1   register-file read port 1 (feeds B)
//   readnum2   register-file read port 2 (feeds A)
//   writenum   register-file write address
//   write      register-file write enable
//   vsel       writeback select: 00 mdata, 01 sximm8, 10 pc, 11 C
//   loadab     load A and B
//   asel       force Ain to zero
//   bsel       select sximm5 for Bin
//   shift      shifter control
//   ALUop      ALU operation
//   loadc      load C
//   loads      load status register
//   load_ir    load instruction register
//   load_pc    load PC
//   reset_pc   PC next-value mux selects RST_PC
//   addr_sel   memory address source: 1 PC, 0 address register
//   load_addr  load address register from datapath_out
//   mem_cmd    memory command: 00 none, 01 read, 10 write
//   halted     high while in HALT
// -----------------------------------------------------------------------------
module cpu_controller #(
    parameter logic [8:0] RST_PC = 9'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ir,
    input  logic [2:0]  Z_out,
    output logic [2:0]  readnum1,
    output logic [2:0]  readnum2,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loadab,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic        load_ir,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        addr_sel,
    output logic        load_addr,
    output logic [1:0]  mem_cmd,
    output logic        halted
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DECODE,
        S_WIMM, S_GETAB, S_EXEC, S_WB,
        S_ADDR, S_LADDR, S_MRD, S_LWB,
        S_GETRD, S_MOVRD, S_MWR, S_HALT
    } state_t;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] VSEL_MDATA = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b01;
    localparam logic [1:0] VSEL_C     = 2'b11;

    // The flags and the reset PC value belong to the datapath; the controller
    // only strobes reset_pc and never branches on the flags.
    logic unused_inputs;
    assign unused_inputs = ^{Z_out, RST_PC};

    // Instruction fields
    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    logic is_movi, is_movr, is_alu, is_ldr, is_str, is_cmp;
    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu  = (opcode == 3'b101);
    assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
    assign is_str  = (opcode == 3'b100) && (op == 2'b00);
    assign is_cmp  = is_alu && (op == 2'b01);

    state_t     state_q, state_d;
    logic [2:0] readnum1_q, readnum1_d;
    logic [2:0] readnum2_q, readnum2_d;
    logic [2:0] writenum_q, writenum_d;
    logic       write_q, write_d;
    logic [1:0] vsel_q, vsel_d;
    logic       loadab_q, loadab_d;
    logic       asel_q, asel_d;
    logic       bsel_q, bsel_d;
    logic [1:0] shift_q, shift_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic       loadc_q, loadc_d;
    logic       loads_q, loads_d;
    logic       load_ir_q, load_ir_d;
    logic       load_pc_q, load_pc_d;
    logic       reset_pc_q, reset_pc_d;
    logic       addr_sel_q, addr_sel_d;
    logic       load_addr_q, load_addr_d;
    logic [1:0] mem_cmd_q, mem_cmd_d;
    logic       halted_q, halted_d;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_IF1;
            S_IF1:    state_d = S_IF2;
            S_IF2:    state_d = S_UPC;
            S_UPC:    state_d = S_DECODE;
            S_DECODE: begin
                if (is_movi)
                    state_d = S_WIMM;
                else if (is_movr || is_alu || is_ldr || is_str)
                    state_d = S_GETAB;
                else
                    state_d = S_HALT;
            end
            S_WIMM:   state_d = S_IF1;
            S_GETAB:  state_d = (is_ldr || is_str) ? S_ADDR : S_EXEC;
            // CMP only updates the status register, so it skips writeback.
            S_EXEC:   state_d = is_cmp ? S_IF1 : S_WB;
            S_WB:     state_d = S_IF1;
            S_ADDR:   state_d = S_LADDR;
            S_LADDR:  state_d = is_str ? S_GETRD : S_MRD;
            S_MRD:    state_d = S_LWB;
            S_LWB:    state_d = S_IF1;
            S_GETRD:  state_d = S_MOVRD;
            S_MOVRD:  state_d = S_MWR;
            S_MWR:    state_d = S_IF1;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RST;
        endcase
    end

    // Output decode of the state being entered, so the registered outputs
    // line up with the state register.
    always_comb begin
        readnum1_d  = 3'd0;
        readnum2_d  = 3'd0;
        writenum_d  = 3'd0;
        write_d     = 1'b0;
        vsel_d      = VSEL_MDATA;
        loadab_d    = 1'b0;
        asel_d      = 1'b0;
        bsel_d      = 1'b0;
        shift_d     = 2'b00;
        alu_op_d    = 2'b00;
        loadc_d     = 1'b0;
        loads_d     = 1'b0;
        load_ir_d   = 1'b0;
        load_pc_d   = 1'b0;
        reset_pc_d  = 1'b0;
        addr_sel_d  = 1'b0;
        load_addr_d = 1'b0;
        mem_cmd_d   = MEM_NONE;
        halted_d    = 1'b0;
        case (state_d)
            S_RST: begin
                reset_pc_d = 1'b1;
                load_pc_d  = 1'b1;
            end
            S_IF1: begin
                mem_cmd_d  = MEM_READ;
                addr_sel_d = 1'b1;
            end
            S_IF2: begin
                mem_cmd_d  = MEM_READ;
                addr_sel_d = 1'b1;
                load_ir_d  = 1'b1;
            end
            S_UPC:    load_pc_d = 1'b1;
            S_WIMM: begin
                vsel_d     = VSEL_IMM8;
                writenum_d = rn;
                write_d    = 1'b1;
            end
            S_GETAB: begin
                loadab_d = 1'b1;
                if (is_movr) begin
                    readnum1_d = rm;
                end else if (is_alu) begin
                    readnum2_d = rn;
                    readnum1_d = rm;
                end else begin
                    readnum2_d = rn;
                end
            end
            S_EXEC: begin
                shift_d = ir[4:3];
                loadc_d = 1'b1;
                if (is_alu) begin
                    alu_op_d = op;
                    loads_d  = 1'b1;
                end else begin
                    // MOV reg passes the shifted operand through as 0 + B.
                    asel_d = 1'b1;
                end
            end
            S_WB: begin
                vsel_d     = VSEL_C;
                writenum_d = rd;
                write_d    = 1'b1;
            end
            S_ADDR: begin
                bsel_d  = 1'b1;
                loadc_d = 1'b1;
            end
            S_LADDR:  load_addr_d = 1'b1;
            S_MRD:    mem_cmd_d   = MEM_READ;
            // Read stays asserted so mdata is still valid while it is written.
            S_LWB: begin
                mem_cmd_d  = MEM_READ;
                vsel_d     = VSEL_MDATA;
                writenum_d = rd;
                write_d    = 1'b1;
            end
            S_GETRD: begin
                readnum1_d = rd;
                loadab_d   = 1'b1;
            end
            S_MOVRD: begin
                asel_d  = 1'b1;
                loadc_d = 1'b1;
            end
            S_MWR:    mem_cmd_d = MEM_WRITE;
            S_HALT:   halted_d  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RST;
            readnum1_q  <= 3'd0;
            readnum2_q  <= 3'd0;
            writenum_q  <= 3'd0;
            write_q     <= 1'b0;
            vsel_q      <= VSEL_MDATA;
            loadab_q    <= 1'b0;
            asel_q      <= 1'b0;
            bsel_q      <= 1'b0;
            shift_q     <= 2'b00;
            alu_op_q    <= 2'b00;
            loadc_q     <= 1'b0;
            loads_q     <= 1'b0;
            load_ir_q   <= 1'b0;
            load_pc_q   <= 1'b1;
            reset_pc_q  <= 1'b1;
            addr_sel_q  <= 1'b0;
            load_addr_q <= 1'b0;
            mem_cmd_q   <= MEM_NONE;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            readnum1_q  <= readnum1_d;
            readnum2_q  <= readnum2_d;
            writenum_q  <= writenum_d;
            write_q     <= write_d;
            vsel_q      <= vsel_d;
            loadab_q    <= loadab_d;
            asel_q      <= asel_d;
            bsel_q      <= bsel_d;
            shift_q     <= shift_d;
            alu_op_q    <= alu_op_d;
            loadc_q     <= loadc_d;
            loads_q     <= loads_d;
            load_ir_q   <= load_ir_d;
            load_pc_q   <= load_pc_d;
            reset_pc_q  <= reset_pc_d;
            addr_sel_q  <= addr_sel_d;
            load_addr_q <= load_addr_d;
            mem_cmd_q   <= mem_cmd_d;
            halted_q    <= halted_d;
        end
    end

    assign readnum1  = readnum1_q;
    assign readnum2  = readnum2_q;
    assign writenum  = writenum_q;
    assign write     = write_q;
    assign vsel      = vsel_q;
    assign loadab    = loadab_q;
    assign asel      = asel_q;
    assign bsel      = bsel_q;
    assign shift     = shift_q;
    assign ALUop     = alu_op_q;
    assign loadc     = loadc_q;
    assign loads     = loads_q;
    assign load_ir   = load_ir_q;
    assign load_pc   = load_pc_q;
    assign reset_pc  = reset_pc_q;
    assign addr_sel  = addr_sel_q;
    assign load_addr = load_addr_q;
    assign mem_cmd   = mem_cmd_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
//
// The stimulus process issues instructions. For each one it asks a reference
// model for the per-cycle control vectors that the instruction should produce,
// and queues them. A monitor pops one expected vector per clock and compares
// it with the DUT outputs. The model describes each instruction as a list of
// steps.
// -----------------------------------------------------------------------------
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ir;
    logic [2:0]  Z_out;
    logic [2:0]  readnum1, readnum2, writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loadab, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic        loadc, loads, load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0]  mem_cmd;
    logic        halted;

    cpu_controller #(.RST_PC(9'd0)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .Z_out(Z_out),
        .readnum1(readnum1), .readnum2(readnum2), .writenum(writenum),
        .write(write), .vsel(vsel), .loadab(loadab), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
        .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
        .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] readnum1;
        logic [2:0] readnum2;
        logic [2:0] writenum;
        logic       write;
        logic [1:0] vsel;
        logic       loadab;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       loadc;
        logic       loads;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctl_t;

    ctl_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_ir_loads = 0;
    int   exp_mem_writes = 0;
    bit   stim_done = 1'b0;

    function automatic ctl_t sample_dut();
        ctl_t g;
        g.readnum1  = readnum1;
        g.readnum2  = readnum2;
        g.writenum  = writenum;
        g.write     = write;
        g.vsel      = vsel;
        g.loadab    = loadab;
        g.asel      = asel;
        g.bsel      = bsel;
        g.shift     = shift;
        g.alu_op    = ALUop;
        g.loadc     = loadc;
        g.loads     = loads;
        g.load_ir   = load_ir;
        g.load_pc   = load_pc;
        g.reset_pc  = reset_pc;
        g.addr_sel  = addr_sel;
        g.load_addr = load_addr;
        g.mem_cmd   = mem_cmd;
        g.halted    = halted;
        return g;
    endfunction

    task automatic push_ctl(input ctl_t c);
        exp_q.push_back(c);
        if (c.load_ir) exp_ir_loads++;
        if (c.mem_cmd == 2'b10) exp_mem_writes++;
    endtask

    task automatic push_rst();
        ctl_t c;
        c = '0;
        c.reset_pc = 1'b1;
        c.load_pc  = 1'b1;
        push_ctl(c);
    endtask

    // Reference model plus driver for one instruction, starting in IF1.
    // limit: number of cycles to run before a mid-instruction reset.
    // halt_n: cycles to observe in HALT. The task ends in IF1 of the next
    // instruction. A reset is applied when asked, on a cut-short instruction,
    // or after a halt.
    task automatic run_instr(input logic [15:0] i, input int limit,
                             input int halt_n, input bit rst_req);
        ctl_t       s[$];
        ctl_t       c;
        int         n;
        bit         halts;
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        opc = i[15:13]; op = i[12:11]; rn = i[10:8];
        rd  = i[7:5];   sh = i[4:3];   rm = i[2:0];
        halts = 1'b0;
        ir    = i;
        Z_out = 3'($urandom);

        c = '0; c.mem_cmd = 2'b01; c.addr_sel = 1'b1; s.push_back(c);
        c.load_ir = 1'b1; s.push_back(c);
        c = '0; c.load_pc = 1'b1; s.push_back(c);
        c = '0; s.push_back(c);
        if (opc == 3'b110 && op == 2'b10) begin
            c = '0; c.vsel = 2'b01; c.writenum = rn; c.write = 1'b1; s.push_back(c);
        end else if (opc == 3'b110 && op == 2'b00) begin
            c = '0; c.readnum1 = rm; c.loadab = 1'b1; s.push_back(c);
            c = '0; c.asel = 1'b1; c.shift = sh; c.loadc = 1'b1; s.push_back(c);
            c = '0; c.vsel = 2'b11; c.writenum = rd; c.write = 1'b1; s.push_back(c);
        end else if (opc == 3'b101) begin
            c = '0; c.readnum2 = rn; c.readnum1 = rm; c.loadab = 1'b1; s.push_back(c);
            c = '0; c.shift = sh; c.alu_op = op; c.loadc = 1'b1; c.loads = 1'b1; s.push_back(c);
            if (op != 2'b01) begin
                c = '0; c.vsel = 2'b11; c.writenum = rd; c.write = 1'b1; s.push_back(c);
            end
        end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
            c = '0; c.readnum2 = rn; c.loadab = 1'b1; s.push_back(c);
            c = '0; c.bsel = 1'b1; c.loadc = 1'b1; s.push_back(c);
            c = '0; c.load_addr = 1'b1; s.push_back(c);
            if (opc == 3'b011) begin
                c = '0; c.mem_cmd = 2'b01; s.push_back(c);
                c.writenum = rd; c.write = 1'b1; s.push_back(c);
            end else begin
                c = '0; c.readnum1 = rd; c.loadab = 1'b1; s.push_back(c);
                c = '0; c.asel = 1'b1; c.loadc = 1'b1; s.push_back(c);
                c = '0; c.mem_cmd = 2'b10; s.push_back(c);
            end
        end else begin
            halts = 1'b1;
            c = '0; c.halted = 1'b1;
            for (int k = 0; k < halt_n; k++) s.push_back(c);
        end

        n = (limit < s.size()) ? limit : s.size();
        for (int k = 0; k < n; k++) push_ctl(s[k]);
        repeat (n - 1) begin @(posedge clk); #1; end
        if (rst_req || halts || n < s.size()) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            push_rst();
            rst_n = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        ctl_t e, g;
        int   cyc, seen_ir_loads, seen_mem_writes;
        cyc = 0; seen_ir_loads = 0; seen_mem_writes = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 50000) begin
                $display("FAIL watchdog: %0d cycles elapsed, required completion", cyc);
                $fatal(1, "bench did not complete");
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = sample_dut();
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL ctl_vector cycle %0d ir=%h: got %h required %h",
                             cyc, ir, g, e);
                end
                if (g.load_ir === 1'b1) seen_ir_loads++;
                if (g.mem_cmd === 2'b10) seen_mem_writes++;
            end else if (stim_done) begin
                n_checks++;
                if (seen_ir_loads != exp_ir_loads) begin
                    n_fail++;
                    $display("FAIL load_ir_count: got %0d required %0d",
                             seen_ir_loads, exp_ir_loads);
                end
                n_checks++;
                if (seen_mem_writes != exp_mem_writes) begin
                    n_fail++;
                    $display("FAIL mem_write_count: got %0d required %0d",
                             seen_mem_writes, exp_mem_writes);
                end
                $display("End of test - %0d assertions evaluated, %0d failures",
                         n_checks, n_fail);
                $finish;
            end
        end
    end

    // Stimulus
    initial begin : stimulus
        logic [15:0] i;
        int          kind, lim;
        rst_n = 1'b0;
        ir    = 16'h0000;
        Z_out = 3'b000;
        @(posedge clk); #1; push_rst();
        @(posedge clk); #1; push_rst();
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(16'hD007, 1000, 0, 1'b0);   // MOV R0,#7
        run_instr(16'hA148, 1000, 0, 1'b0);   // ADD R2,R1,R0 LSL#1
        run_instr(16'hA900, 1000, 0, 1'b0);   // CMP R1,R0
        run_instr(16'h6162, 1000, 0, 1'b0);   // LDR R3,[R1,#2]
        run_instr(16'h8162, 1000, 0, 1'b0);   // STR R3,[R1,#2]
        run_instr(16'hE000, 1000, 20, 1'b0);  // HALT, then reset
        run_instr(16'h8162, 9, 0, 1'b1);      // STR cut off in MOVRD

        for (int t = 0; t < 80; t++) begin
            i    = 16'($urandom);
            kind = $urandom_range(0, 11);
            case (kind)
                0, 1: i[15:11] = 5'b11010;
                2:    i[15:11] = 5'b11000;
                3, 4, 5: i[15:13] = 3'b101;
                6, 7: i[15:11] = 5'b01100;
                8, 9: i[15:11] = 5'b10000;
                default: ;
            endcase
            lim = 1000;
            if ($urandom_range(0, 7) == 0) lim = $urandom_range(1, 10);
            run_instr(i, lim, $urandom_range(1, 5), 1'b0);
        end
        stim_done = 1'b1;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Moore-style control FSM and instruction decoder that sits directly upstream of the datapath.
- Takes the 16-bit instruction register contents and the datapath status flags.
- Sequences fetch, decode, execute, memory access and writeback.
- Drives every datapath control input, plus the memory command, PC and address-register strobes.

Parameters:
- RST_PC, 9'd0, PC value reloaded in the RST state.

Ports:
- clk  input  1  single system clock; all state changes on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- ir  input  16  instruction: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm
- Z_out  input  3  status flags {V,N,Z} from the datapath status register (observed only)
- readnum1  output  3  register-file read port 1; feeds B
- readnum2  output  3  register-file read port 2; feeds A
- writenum  output  3  register-file write address
- write  output  1  register-file write enable
- vsel  output  2  writeback mux select: 00 mdata, 01 sximm8, 10 pc, 11 C
- loadab  output  1  load A and B together
- asel  output  1  1 forces Ain to 0
- bsel  output  1  1 selects sximm5 for Bin
- shift  output  2  shifter control
- ALUop  output  2  ALU operation
- loadc  output  1  load C
- loads  output  1  load status register
- load_ir  output  1  load instruction register
- load_pc  output  1  load PC
- reset_pc  output  1  PC next-value mux selects RST_PC
- addr_sel  output  1  1: memory address = PC; 0: address register
- load_addr  output  1  load address register from datapath_out
- mem_cmd  output  2  00 none, 01 read, 10 write
- halted  output  1  high in HALT state

Behaviour:
- Outputs are pure functions of the state register. Every output defaults to 0 in each state; only the listed signals are asserted.
- Reset:
  - rst_n=0 at an edge forces state RST, including mid-instruction, and discards any partial operation.
  - RST asserts reset_pc=1 and load_pc=1; all other outputs are 0.
  - After release: RST -> IF1.
- Fetch:
  - IF1: mem_cmd=01, addr_sel=1.
  - IF2: mem_cmd=01, addr_sel=1, load_ir=1.
  - UPC: load_pc=1 (PC+1).
  - DECODE: no strobes. Branches on {opcode,op}.
- MOV imm (110,10): WIMM: vsel=01, writenum=Rn, write=1 -> IF1.
- MOV reg (110,00):
  - GETAB: readnum1=Rm, loadab=1.
  - EXEC: asel=1, bsel=0, shift=ir[4:3], ALUop=00, loadc=1.
  - WB: vsel=11, writenum=Rd, write=1 -> IF1.
- ALU ops (101, op -> ALUop: 00 ADD, 01 CMP, 10 AND, 11 MVN):
  - GETAB: readnum2=Rn, readnum1=Rm, loadab=1.
  - EXEC: asel=0, bsel=0, shift=ir[4:3], ALUop=op, loadc=1, loads=1 for every op.
  - CMP goes EXEC -> IF1 with no writeback; all others go EXEC -> WB.
- LDR (011,00):
  - GETAB: readnum2=Rn, loadab=1.
  - ADDR: asel=0, bsel=1, ALUop=00, shift=00, loadc=1.
  - LADDR: load_addr=1.
  - MRD: mem_cmd=01, addr_sel=0.
  - LWB: mem_cmd=01, addr_sel=0, vsel=00, writenum=Rd, write=1 -> IF1.
- STR (100,00):
  - GETAB, ADDR and LADDR as for LDR.
  - GETRD: readnum1=Rd, loadab=1.
  - MOVRD: asel=1, bsel=0, shift=00, ALUop=00, loadc=1.
  - MWR: mem_cmd=10, addr_sel=0 -> IF1.
- HALT (111) and any unlisted {opcode,op}: HALT state. halted=1, no strobes, stays until rst_n=0.
- shift is forced to 00 in every state except EXEC. loads=1 only in EXEC of opcode 101.
- Cycle counts from IF1 to the next IF1: MOV imm 5, MOV reg 7, ADD/AND/MVN 7, CMP 6, LDR 9, STR 10.
- Writing the same register read in GETAB is legal: the read has already been captured in A/B.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release -> one RST cycle (reset_pc=1, load_pc=1), then IF1 with mem_cmd=01 and addr_sel=1.
- ir=0xD007 (MOV R0,#7) -> 5 cycles; WIMM shows vsel=01, writenum=0, write=1; load_ir=1 seen exactly once.
- ir=0xA148 (ADD R2,R1,R0 LSL#1) -> GETAB: readnum2=1, readnum1=0. EXEC: shift=01, ALUop=00, loadc=1, loads=1. WB: writenum=2, vsel=11. 7 cycles total.
- ir=0xA900 (CMP R1,R0) -> EXEC: ALUop=01, loads=1; write never asserted; back to IF1 after 6 cycles.
- ir=0x6162 (LDR R3,[R1,#2]) then ir=0x8162 (STR) -> LDR: bsel=1 in ADDR, load_addr=1, two mem_cmd=01 cycles with addr_sel=0, writenum=3 with vsel=00. STR: readnum1=3 in GETRD, mem_cmd=10 in MWR. Totals 9 and 10 cycles.
- ir=0xE000 -> halted=1 held for 20 cycles with no strobes. Separately, assert rst_n=0 during the STR MOVRD state -> next state RST, mem_cmd=10 never issued.
